// File: rtl/sum_collect.sv
`default_nettype none
// ============================================================================
//  Module   : sum_collect
//  Purpose  : Result collector for sum_N. It holds one result, queues it in a
//             FIFO, acks the producer, and keeps a saturating total and a count.
//  Revision : 1.0
// ============================================================================
module sum_collect #(
  parameter int DEPTH = 4,
  parameter int W     = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] sum_in,
  input  logic         sum_valid_in,
  output logic         sum_ack,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   total,
  output logic [3:0]   count,
  output logic         fifo_full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t        r_state;
  logic [W-1:0]  r_hold;
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_occ;
  logic [7:0]    r_total;
  logic [3:0]    r_count;
  logic          r_ack;

  logic          w_pop;
  logic          w_push;
  logic [8:0]    w_sum;
  logic [7:0]    w_total_next;

  // Full/valid come only from the registered occupancy counter.
  assign out_valid = (r_occ != '0);
  assign fifo_full = (r_occ == C_DEPTH);
  assign out_data  = r_mem[r_rptr];
  assign sum_ack   = r_ack;
  assign total     = r_total;
  assign count     = r_count;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign w_pop  = out_valid & out_ready;
  assign w_push = (r_state == S_HOLD) & (~fifo_full | w_pop);

  assign w_sum        = {1'b0, r_total} + 9'(r_hold);
  assign w_total_next = w_sum[8] ? 8'hFF : w_sum[7:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_hold  <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_occ   <= '0;
      r_total <= '0;
      r_count <= '0;
      r_ack   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_ack <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (sum_valid_in) begin
            r_hold  <= sum_in;
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (w_push) begin
            r_ack   <= 1'b1;
            r_state <= S_ACK;
          end
        end
        S_ACK: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      if (w_push) begin
        r_mem[r_wptr] <= r_hold;
        r_wptr        <= r_wptr + 1'b1;
        r_total       <= w_total_next;
        r_count       <= r_count + 1'b1;
      end

      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end

      if (w_push && !w_pop) begin
        r_occ <= r_occ + 1'b1;
      end else if (!w_push && w_pop) begin
        r_occ <= r_occ - 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sum_collect.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sum_collect
//  Purpose  : Scoreboard bench for sum_collect: queued results, ack timing,
//             saturating total, count wrap, busy-ignore and async reset.
//  Revision : 1.0
// ============================================================================
module tb_sum_collect;

  logic       clk;
  logic       reset;
  logic [4:0] sum_in;
  logic       sum_valid_in;
  logic       sum_ack;
  logic [4:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] total;
  logic [3:0] count;
  logic       fifo_full;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         total_m  = 0;
  int         count_m  = 0;
  logic [4:0] exp_q[$];

  sum_collect #(.DEPTH(4), .W(5)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .sum_in      (sum_in),
    .sum_valid_in(sum_valid_in),
    .sum_ack     (sum_ack),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .total       (total),
    .count       (count),
    .fifo_full   (fifo_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Pop monitor: a pop happens at the next rising edge when valid & ready.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("pop_unexpected", {27'd0, out_data}, 32'hFFFF_FFFF);
      end else begin
        check("pop_data", {27'd0, out_data}, {27'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic on_ack(input logic [4:0] v);
    total_m = (total_m + int'(v) > 255) ? 255 : total_m + int'(v);
    count_m = (count_m + 1) % 16;
    check("total", {24'd0, total}, total_m);
    check("count", {28'd0, count}, count_m);
  endtask

  task automatic drive(input logic [4:0] v);
    @(posedge clk); #1;
    sum_in       = v;
    sum_valid_in = 1'b1;
    exp_q.push_back(v);
    @(posedge clk); #1;
    sum_valid_in = 1'b0;
  endtask

  task automatic wait_ack(input logic [4:0] v, input int exp_lat);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    while (n < 40 && !got) begin
      @(negedge clk);
      n++;
      if (sum_ack) got = 1'b1;
    end
    check("ack_seen", {31'd0, got}, 1);
    if (got) begin
      if (exp_lat > 0) check("ack_latency", n, exp_lat);
      on_ack(v);
      @(negedge clk);
      check("ack_one_cycle", {31'd0, sum_ack}, 0);
    end
  endtask

  task automatic send(input logic [4:0] v);
    drive(v);
    wait_ack(v, 2);
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    sum_valid_in = 1'b0;
    out_ready    = 1'b0;
    exp_q.delete();
    total_m = 0;
    count_m = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {31'd0, out_valid}, 0);
    check("rst_ack",   {31'd0, sum_ack}, 0);
    check("rst_data",  {27'd0, out_data}, 0);
    check("rst_total", {24'd0, total}, 0);
    check("rst_count", {28'd0, count}, 0);
    check("rst_full",  {31'd0, fifo_full}, 0);
    reset = 1'b1;
  endtask

  task automatic drain();
    int n;
    @(posedge clk); #1;
    out_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (out_valid && n < 20);
    check("drain_empty", {31'd0, out_valid}, 0);
    out_ready = 1'b0;
  endtask

  initial begin
    int acks;
    sum_in       = '0;
    sum_valid_in = 1'b0;
    out_ready    = 1'b0;
    reset        = 1'b0;

    // Reset and single result
    do_reset();
    send(5'd10);
    check("single_valid", {31'd0, out_valid}, 1);
    check("single_data",  {27'd0, out_data}, 10);
    drain();

    // Fill and backpressure
    send(5'd1);
    send(5'd3);
    send(5'd6);
    send(5'd10);
    check("fill_full", {31'd0, fifo_full}, 1);
    drive(5'd15);
    repeat (3) begin
      @(negedge clk);
      check("full_no_ack", {31'd0, sum_ack}, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("bp_ack", {31'd0, sum_ack}, 1);
    check("bp_full_stays", {31'd0, fifo_full}, 1);
    on_ack(5'd15);
    drain();

    // Drain order and pointer wrap
    out_ready = 1'b1;
    foreach (exp_q[i]) begin end
    begin
      logic [4:0] seq [6];
      seq = '{5'd28, 5'd21, 5'd15, 5'd10, 5'd6, 5'd3};
      for (int i = 0; i < 6; i++) begin
        send(seq[i]);
        check("wrap_not_full", {31'd0, fifo_full}, 0);
      end
    end
    repeat (3) @(negedge clk);
    check("wrap_empty", {31'd0, out_valid}, 0);
    out_ready = 1'b0;

    // Saturation and count wrap
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      send(5'd28);
      if (i == 8)  check("sat_9th",    {24'd0, total}, 252);
      if (i == 9)  check("sat_10th",   {24'd0, total}, 255);
      if (i == 15) check("count_16th", {28'd0, count}, 0);
      if (i == 16) check("count_17th", {28'd0, count}, 1);
    end
    check("sat_hold", {24'd0, total}, 255);
    repeat (3) @(negedge clk);
    out_ready = 1'b0;

    // Ignore sum_valid_in while busy (FIFO full keeps the FSM in HOLD)
    do_reset();
    send(5'd1);
    send(5'd2);
    send(5'd3);
    send(5'd4);
    @(posedge clk); #1;
    sum_in       = 5'd6;
    sum_valid_in = 1'b1;
    exp_q.push_back(5'd6);
    @(posedge clk); #1;
    sum_in = 5'd7;
    repeat (3) begin
      @(posedge clk); #1;
    end
    sum_valid_in = 1'b0;
    out_ready    = 1'b1;
    acks = 0;
    repeat (16) begin
      @(negedge clk);
      if (sum_ack) begin
        acks++;
        on_ack(5'd6);
      end
    end
    check("busy_one_ack", acks, 1);
    check("busy_empty", {31'd0, out_valid}, 0);
    out_ready = 1'b0;

    // Async reset while in HOLD with two entries queued
    do_reset();
    send(5'd5);
    send(5'd9);
    drive(5'd12);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_valid", {31'd0, out_valid}, 0);
    check("async_ack",   {31'd0, sum_ack}, 0);
    check("async_total", {24'd0, total}, 0);
    check("async_count", {28'd0, count}, 0);
    check("async_full",  {31'd0, fifo_full}, 0);
    exp_q.delete();
    total_m = 0;
    count_m = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    send(5'd20);
    check("post_rst_data", {27'd0, out_data}, 20);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
